apb4_reg_slave: RTL and testbench
=================================

// Module: apb4_reg_slave
// PURPOSE
//  APB4 completer at the far end of the bus from our APB master: a bank of NUM_REGS x DATA_WIDTH
//  control/status registers with programmable wait states, PSTRB byte-lane writes and PSLVERR.
//  Register 0 is a read-only status word driven by status_in. Registers 1..NUM_REGS-1 are R/W
//  and drive reg_out. Register NUM_REGS-1 is secure-only.
// PARAMETERS
//  ADDR_WIDTH   32  PADDR width
//  DATA_WIDTH   32  PWDATA/PRDATA width; fixed at 32 in this release
//  NUM_REGS     16  number of 32-bit word registers; power of 2, >=2
//  WAIT_STATES  2   PREADY-low access cycles before completion; 0..15
//  BASE_ADDR    0   byte base address; aligned to NUM_REGS*4
// PORTS
//  PCLK       in   1                    APB clock
//  PRESETn    in   1                    async active-low reset
//  PSEL       in   1                    slave select
//  PENABLE    in   1                    access phase
//  PWRITE     in   1                    1=write, 0=read
//  PADDR      in   ADDR_WIDTH           byte address
//  PWDATA     in   DATA_WIDTH           write data
//  PSTRB      in   DATA_WIDTH/8         write byte strobes
//  PPROT      in   3                    [1]=1 non-secure
//  PRDATA     out  DATA_WIDTH           read data
//  PREADY     out  1                    transfer complete
//  PSLVERR    out  1                    transfer error, valid only with PREADY
//  status_in  in   DATA_WIDTH           sampled value for reg 0
//  reg_out    out  NUM_REGS*DATA_WIDTH  flattened R/W regs; slice i = reg i; slice 0 = 0
//  wr_pulse   out  NUM_REGS             1-cycle pulse when reg i is committed
// BEHAVIOUR
//  - Clock and reset: PCLK; reset PRESETn, asynchronous, active-low.
//  - Reset values: all regs 0; PRDATA=0, PREADY=0, PSLVERR=0, wr_pulse=0; FSM in IDLE.
//  - FSM states: IDLE, WAIT, RESP. All transitions happen on the PCLK rising edge.
//    IDLE->WAIT on PSEL&!PENABLE (setup): latch PADDR/PWRITE/PWDATA/PSTRB/PPROT and load wait_cnt=WAIT_STATES.
//    WAIT: while PSEL&PENABLE&wait_cnt!=0, decrement; on wait_cnt==0 go RESP.
//    RESP: PREADY=1 for exactly one cycle, then go IDLE.
//    A setup seen in that same IDLE cycle is taken immediately, so back-to-back transfers carry no dead cycle.
//  - Latency: PREADY rises in access cycle WAIT_STATES+1. WAIT_STATES=0 gives zero-wait (PREADY in 1st access cycle).
//  - PREADY=0 in every cycle except the completion cycle.
//  - Error check, evaluated on latched values; PSLVERR=1 with PREADY if any of:
//    * PADDR outside [BASE_ADDR, BASE_ADDR+NUM_REGS*4);
//    * PADDR[1:0]!=0;
//    * write to reg 0;
//    * PPROT[1]=1 access (read or write) to reg NUM_REGS-1.
//  - On error: no register changes, wr_pulse stays 0, PRDATA=0.
//  - Write commit: on the completion edge, and only if no error. For byte b, reg[b*8+:8]=PWDATA[b*8+:8] when PSTRB[b].
//    PSTRB=0 is a legal no-op write, but wr_pulse still fires.
//  - Read: PRDATA = reg value (reg 0 = status_in sampled in the completion cycle).
//    Valid only while PREADY=1; PRDATA=0 otherwise. PSTRB is ignored on reads.
//  - PSEL deasserted while in WAIT (master violation): abort to IDLE; no commit, no PREADY.
//  - PRESETn asserted mid-transfer: immediate abort; regs reset; the pending write is lost.
//  - Read of a register in the cycle after its write returns the new value.
// STRUCTURE
//  - Shared package apb4_pkg: FSM state enum (IDLE/WAIT/RESP) and PPROT bit indices
//    (PROT_PRIV=0, PROT_NSEC=1, PROT_INSTR=2). The master's IDLE/SETUP/ACCESS encoding also moves there.
//  - One sub-module: apb4_reg_bank, holding storage, byte-strobe merge, read mux and wr_pulse.
//    The top level holds the FSM, wait counter, address decode and error logic.
// TESTING
//  1. WAIT_STATES=2; write 0xDEADBEEF to 0x04 with PSTRB=0xF -> PREADY low 2 access cycles,
//     high on 3rd; PSLVERR=0; reg_out[63:32]=0xDEADBEEF; wr_pulse[1] single pulse.
//  2. Reg1=0xDEADBEEF; write 0x11223344 with PSTRB=0x5 to 0x04, then read 0x04 -> PRDATA=0xDE22BE44.
//  3. Error cases, each -> PSLVERR=1 with PREADY and reg unchanged:
//     write to 0x00; read at 0x40 (NUM_REGS=16, PRDATA=0); write at 0x06; PPROT=3'b010 read of 0x3C.
//  4. status_in=0xA5A5_0001; read 0x00 -> PRDATA=0xA5A50001, PSLVERR=0;
//     PPROT=3'b000 write 0x3C=0x1234 -> committed.
//  5. WAIT_STATES=0; back-to-back write 0x08 then read 0x08 -> each completes in its first access cycle;
//     read returns the written value; no idle cycle between transfers.
//  6. Assert PRESETn low in the 2nd WAIT cycle of a write to 0x04 -> PREADY stays 0;
//     after release reg1=0 and all outputs are at reset values.

Source files
------------

// File: rtl/apb4_pkg.sv
// Shared APB4 definitions: FSM encodings, PPROT bit positions, write payload and byte merge.
package apb4_pkg;

  localparam int unsigned APB_DW     = 32;
  localparam int unsigned APB_SW     = APB_DW / 8;
  localparam int unsigned WAIT_CNT_W = 4;

  // PPROT bit positions
  localparam int unsigned PROT_PRIV  = 0;
  localparam int unsigned PROT_NSEC  = 1;
  localparam int unsigned PROT_INSTR = 2;

  // Completer-side transfer states
  typedef enum logic [1:0] {
    SLV_IDLE = 2'd0,
    SLV_WAIT = 2'd1,
    SLV_RESP = 2'd2
  } slv_state_e;

  // Requester-side transfer states (used by our APB master)
  typedef enum logic [1:0] {
    MST_IDLE   = 2'd0,
    MST_SETUP  = 2'd1,
    MST_ACCESS = 2'd2
  } mst_state_e;

  // Write payload captured in the setup phase
  typedef struct packed {
    logic [APB_DW-1:0] data;
    logic [APB_SW-1:0] strb;
  } apb_wpay_t;

  // Replace the byte lanes of old_val selected by the strobes
  function automatic logic [APB_DW-1:0] strb_merge(input logic [APB_DW-1:0] old_val,
                                                   input apb_wpay_t         wp);
    logic [APB_DW-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(APB_SW); b++) begin
      if (wp.strb[b]) res[b*8 +: 8] = wp.data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb4_reg_bank.sv
// Register storage for the APB4 completer: strobe merge on commit, read mux, commit pulses.
module apb4_reg_bank
  import apb4_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  apb_wpay_t                      wpay,
  input  logic [IDX_W-1:0]               ridx,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [DATA_WIDTH-1:0]          rd_data_c,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Commit a strobed write and flag the committed register for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (we) begin
        regs_q[widx]   <= strb_merge(regs_q[widx], wpay);
        wr_pulse[widx] <= 1'b1;
      end
    end
  end

  // Register 0 reads the live status word; the others read storage
  always_comb begin
    rd_data_c = regs_q[ridx];
    if (ridx == '0) rd_data_c = status_in;
  end

  // Flattened view of the R/W registers; slot 0 is the status word and reads as zero here
  assign reg_out[DATA_WIDTH-1:0] = '0;
  for (genvar i = 1; i < int'(NUM_REGS); i++) begin : g_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: rtl/apb4_reg_slave.sv
// APB4 completer: transfer FSM with programmable wait states, decode/error checks, register bank.
module apb4_reg_slave
  import apb4_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned OFS_W = IDX_W + 2;
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam logic [IDX_W-1:0] SEC_IDX = IDX_W'(NUM_REGS - 1);

  slv_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  take_c, done_c, commit_c;

  logic                  lat_write, lat_err;
  logic [IDX_W-1:0]      lat_idx;
  apb_wpay_t             lat_wpay;

  logic                  live_err;
  logic [IDX_W-1:0]      live_idx;
  logic                  cur_write, cur_err;
  logic [IDX_W-1:0]      cur_idx;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  unused_prot;

  assign unused_prot = ^{PPROT[PROT_PRIV], PPROT[PROT_INSTR]};

  // Decode of the request currently on the bus
  always_comb begin
    live_idx = PADDR[OFS_W-1:2];
    live_err = 1'b0;
    if ((PADDR >> OFS_W) != (BASE_ADDR >> OFS_W)) live_err = 1'b1;
    if (PADDR[1:0] != 2'b00)                      live_err = 1'b1;
    if (PWRITE && (live_idx == '0))               live_err = 1'b1;
    if (PPROT[PROT_NSEC] && (live_idx == SEC_IDX)) live_err = 1'b1;
  end

  // A zero-wait transfer completes on the setup edge, before the latch holds it
  assign cur_write = (state_q == SLV_IDLE) ? PWRITE   : lat_write;
  assign cur_err   = (state_q == SLV_IDLE) ? live_err : lat_err;
  assign cur_idx   = (state_q == SLV_IDLE) ? live_idx : lat_idx;

  // State and wait counter registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= SLV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait countdown, capture and completion strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    take_c   = 1'b0;
    done_c   = 1'b0;
    commit_c = 1'b0;
    unique case (state_q)
      SLV_IDLE: begin
        if (PSEL && !PENABLE) begin
          take_c = 1'b1;
          cnt_d  = WAIT_LOAD;
          if (ZERO_WAIT) begin
            state_d = SLV_RESP;
            done_c  = 1'b1;
          end else begin
            state_d = SLV_WAIT;
          end
        end
      end
      SLV_WAIT: begin
        if (!PSEL) begin
          state_d = SLV_IDLE;
        end else if (PENABLE) begin
          if (cnt_q == '0) begin
            state_d = SLV_RESP;
            done_c  = 1'b1;
          end else begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
          end
        end
      end
      SLV_RESP: begin
        state_d  = SLV_IDLE;
        commit_c = lat_write && !lat_err;
      end
      default: state_d = SLV_IDLE;
    endcase
  end

  // Capture the request in the setup phase
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wpay  <= '0;
    end else if (take_c) begin
      lat_write <= PWRITE;
      lat_err   <= live_err;
      lat_idx   <= live_idx;
      lat_wpay  <= '{data: PWDATA, strb: PSTRB};
    end
  end

  // Response outputs, valid only in the completion cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= done_c;
      PSLVERR <= done_c && cur_err;
      PRDATA  <= (done_c && !cur_err && !cur_write) ? rd_data_c : '0;
    end
  end

  apb4_reg_bank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .we        (commit_c),
    .widx      (lat_idx),
    .wpay      (lat_wpay),
    .ridx      (cur_idx),
    .status_in (status_in),
    .rd_data_c (rd_data_c),
    .reg_out   (reg_out),
    .wr_pulse  (wr_pulse)
  );

endmodule

// File: tb/tb_apb4_reg_slave.sv
// Bench for apb4_reg_slave: a 2-wait-state instance (unit 0) and a zero-wait instance (unit 1).
module tb_apb4_reg_slave;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel    [2];
  logic         penable [2];
  logic         pwrite  [2];
  logic [31:0]  paddr   [2];
  logic [31:0]  pwdata  [2];
  logic [3:0]   pstrb   [2];
  logic [2:0]   pprot   [2];
  logic [31:0]  prdata  [2];
  logic         pready  [2];
  logic         pslverr [2];
  logic [31:0]  status  [2];
  logic [511:0] reg_out [2];
  logic [15:0]  wr_pulse[2];

  int   ws_of [2] = '{2, 0};
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  vec_t vecs [14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb4_reg_slave #(.WAIT_STATES(2)) dut_ws2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .status_in(status[0]), .reg_out(reg_out[0]), .wr_pulse(wr_pulse[0])
  );

  apb4_reg_slave #(.WAIT_STATES(0)) dut_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .status_in(status[1]), .reg_out(reg_out[1]), .wr_pulse(wr_pulse[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One full transfer starting just after a rising edge; returns just after the edge ending it
  task automatic xfer(input int u, input vec_t v, input string tag);
    int   n;
    exp_t e;
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = v.write; paddr[u] = v.addr;
    pwdata[u] = v.wdata; pstrb[u] = v.strb; pprot[u] = v.prot;
    sb_q.push_back('{rdata: v.rdata, err: v.err});
    @(posedge clk); #1;
    penable[u] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (pready[u] || n >= 40) break;
      @(posedge clk); #1;
    end
    check({tag, " pready"}, 64'(pready[u]), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(ws_of[u] + 1));
    e = sb_q.pop_front();
    check({tag, " prdata"}, 64'(prdata[u]), 64'(e.rdata));
    check({tag, " pslverr"}, 64'(pslverr[u]), 64'(e.err));
    @(posedge clk); #1;
    psel[u] = 1'b0; penable[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int   c0;
    logic seen;
    vec_t v;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      psel[u] = 0; penable[u] = 0; pwrite[u] = 0; paddr[u] = '0;
      pwdata[u] = '0; pstrb[u] = '0; pprot[u] = '0;
    end
    status[0] = 32'hA5A5_0001;
    status[1] = 32'h0;

    //              write addr        wdata          strb  prot    rdata          err
    vecs[0]  = '{1, 32'h04, 32'h1122_3344, 4'h5, 3'b000, 32'h0,         0};
    vecs[1]  = '{0, 32'h04, 32'h0,         4'hF, 3'b000, 32'hDE22_BE44, 0};
    vecs[2]  = '{1, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0,         1};
    vecs[3]  = '{0, 32'h40, 32'h0,         4'h0, 3'b000, 32'h0,         1};
    vecs[4]  = '{1, 32'h06, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0,         1};
    vecs[5]  = '{0, 32'h3C, 32'h0,         4'h0, 3'b010, 32'h0,         1};
    vecs[6]  = '{0, 32'h04, 32'h0,         4'h0, 3'b000, 32'hDE22_BE44, 0};
    vecs[7]  = '{0, 32'h00, 32'h0,         4'h0, 3'b000, 32'hA5A5_0001, 0};
    vecs[8]  = '{1, 32'h3C, 32'h0000_1234, 4'hF, 3'b000, 32'h0,         0};
    vecs[9]  = '{0, 32'h3C, 32'h0,         4'h0, 3'b000, 32'h0000_1234, 0};
    vecs[10] = '{1, 32'h3C, 32'hFFFF_FFFF, 4'hF, 3'b010, 32'h0,         1};
    vecs[11] = '{0, 32'h3C, 32'h0,         4'hF, 3'b000, 32'h0000_1234, 0};
    vecs[12] = '{1, 32'h08, 32'hFFFF_FFFF, 4'h0, 3'b000, 32'h0,         0};
    vecs[13] = '{0, 32'h08, 32'h0,         4'h0, 3'b000, 32'h0,         0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset pready", 64'(pready[0]), 64'd0);
    check("reset pslverr", 64'(pslverr[0]), 64'd0);
    check("reset prdata", 64'(prdata[0]), 64'd0);
    check("reset wr_pulse", 64'(wr_pulse[0]), 64'd0);
    check("reset reg_out", 64'(reg_out[0] == '0), 64'd1);
    @(posedge clk); #1;

    // Full-word write with two wait states, then the commit pulse
    v = '{1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, 0};
    xfer(0, v, "wr_deadbeef");
    @(negedge clk);
    check("wr_pulse set", 64'(wr_pulse[0]), 64'h2);
    check("reg1 value", 64'(reg_out[0][63:32]), 64'hDEAD_BEEF);
    @(negedge clk);
    check("wr_pulse clear", 64'(wr_pulse[0]), 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      xfer(0, vecs[i], $sformatf("vec%0d", i));
      idle(1);
    end
    check("reg0 slice", 64'(reg_out[0][31:0]), 64'h0);
    check("reg1 final", 64'(reg_out[0][63:32]), 64'hDE22_BE44);
    check("reg2 final", 64'(reg_out[0][95:64]), 64'h0);
    check("reg15 final", 64'(reg_out[0][511:480]), 64'h1234);

    // Zero-wait back-to-back write then read
    c0 = cyc;
    v = '{1, 32'h08, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0, 0};
    xfer(1, v, "b2b_wr");
    v = '{0, 32'h08, 32'h0, 4'h0, 3'b000, 32'hCAFE_F00D, 0};
    xfer(1, v, "b2b_rd");
    check("b2b cycles", 64'(cyc - c0), 64'd4);
    check("b2b reg2", 64'(reg_out[1][95:64]), 64'hCAFE_F00D);
    idle(1);

    // PSEL dropped during the wait phase: transfer must vanish
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h08;
    pwdata[0] = 32'h5555_5555; pstrb[0] = 4'hF; pprot[0] = 3'b000;
    @(posedge clk); #1; penable[0] = 1;
    @(posedge clk); #1; psel[0] = 0; penable[0] = 0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pready[0] || wr_pulse[0] != '0) seen = 1'b1;
    end
    check("abort no response", 64'(seen), 64'd0);
    check("abort reg2", 64'(reg_out[0][95:64]), 64'h0);
    @(posedge clk); #1;

    // Reset in the second wait cycle of a write
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h04;
    pwdata[0] = 32'h0F0F_0F0F; pstrb[0] = 4'hF; pprot[0] = 3'b000;
    @(posedge clk); #1; penable[0] = 1;
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    check("rst pready", 64'(pready[0]), 64'd0);
    @(posedge clk); #1; psel[0] = 0; penable[0] = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready[0]) seen = 1'b1;
    end
    check("rst no pready", 64'(seen), 64'd0);
    check("rst pslverr", 64'(pslverr[0]), 64'd0);
    check("rst prdata", 64'(prdata[0]), 64'd0);
    check("rst wr_pulse", 64'(wr_pulse[0]), 64'd0);
    check("rst reg1", 64'(reg_out[0][63:32]), 64'h0);
    check("rst reg_out", 64'(reg_out[0] == '0), 64'd1);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
